// File: rtl/anneal_scheduler_if.sv
// Statistics-record valid/ready bus between anneal_scheduler (master) and its consumer (slave).
`timescale 1ns/1ps
interface anneal_scheduler_if #(
  parameter int unsigned TEMP_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH  = 32
);
  localparam int unsigned SQ_WIDTH = 48;

  logic                        stat_valid;
  logic                        stat_ready;
  logic [TEMP_WIDTH-1:0]       stat_temp;
  logic signed [ACC_WIDTH-1:0] stat_energy_sum;
  logic [ACC_WIDTH-1:0]        stat_mag_sum;
  logic [CNT_WIDTH-1:0]        stat_samples;
  logic [SQ_WIDTH-1:0]         stat_energy_sq_sum;

  modport master (
    output stat_valid, stat_temp, stat_energy_sum, stat_mag_sum, stat_samples, stat_energy_sq_sum,
    input  stat_ready
  );

  modport slave (
    input  stat_valid, stat_temp, stat_energy_sum, stat_mag_sum, stat_samples, stat_energy_sq_sum,
    output stat_ready
  );
endinterface

// File: rtl/anneal_scheduler.sv
// Annealing run sequencer for lattice_grid: cooling schedule, update pulses, per-temperature statistics.
// Optional feature macro ANNEAL_SQSUM_EN adds the sum-of-squared-energy accumulator.
`timescale 1ns/1ps
module anneal_scheduler #(
  parameter int unsigned TEMP_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [TEMP_WIDTH-1:0] cfg_t_start_i,
  input  logic [TEMP_WIDTH-1:0] cfg_t_end_i,
  input  logic [TEMP_WIDTH-1:0] cfg_t_step_i,
  input  logic [CNT_WIDTH-1:0]  cfg_sweeps_i,
  input  logic [CNT_WIDTH-1:0]  cfg_burn_in_i,
  input  logic [CNT_WIDTH-1:0]  cfg_gap_i,
  output logic                  update_enable_o,
  output logic [TEMP_WIDTH-1:0] temperature_o,
  input  logic signed [15:0]    lattice_energy_i,
  input  logic signed [15:0]    lattice_mag_i,
  output logic                  busy_o,
  output logic                  done_o,
  anneal_scheduler_if.master    stat_if
);
  localparam int unsigned LAT_WIDTH = 16;
`ifdef ANNEAL_SQSUM_EN
  localparam int unsigned SQ_WIDTH  = 48;
  localparam int unsigned PRD_WIDTH = 2 * LAT_WIDTH;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_SETTLE,
    S_SAMPLE,
    S_REPORT,
    S_FIN
  } state_e;

  state_e                state_q, state_d;
  logic [TEMP_WIDTH-1:0] t_end_q, t_end_d;
  logic [TEMP_WIDTH-1:0] t_step_q, t_step_d;
  logic [TEMP_WIDTH-1:0] temp_q, temp_d;
  logic [CNT_WIDTH-1:0]  sweeps_q, sweeps_d;
  logic [CNT_WIDTH-1:0]  burn_q, burn_d;
  logic [CNT_WIDTH-1:0]  gap_q, gap_d;
  logic [CNT_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CNT_WIDTH-1:0]  sweep_idx_q, sweep_idx_d;
  logic [CNT_WIDTH-1:0]  samples_q, samples_d;
  logic [ACC_WIDTH-1:0]  esum_q, esum_d;
  logic [ACC_WIDTH-1:0]  msum_q, msum_d;
  logic                  stat_valid_q, stat_valid_d;
  logic [TEMP_WIDTH-1:0] stat_temp_q, stat_temp_d;
  logic [ACC_WIDTH-1:0]  stat_esum_q, stat_esum_d;
  logic [ACC_WIDTH-1:0]  stat_msum_q, stat_msum_d;
  logic [CNT_WIDTH-1:0]  stat_samples_q, stat_samples_d;
  logic                  upd_q, upd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef ANNEAL_SQSUM_EN
  logic [SQ_WIDTH-1:0]         sqsum_q, sqsum_d;
  logic [SQ_WIDTH-1:0]         stat_sq_q, stat_sq_d;
  logic signed [PRD_WIDTH-1:0] e_ext;
  logic [PRD_WIDTH-1:0]        e_sq;
`endif

  logic signed [LAT_WIDTH:0] mag_ext;
  logic [LAT_WIDTH:0]        mag_abs;
  logic [CNT_WIDTH:0]        idx_inc;
  logic                      sweep_last;
  logic                      last_temp;

  // One extra bit keeps |-32768| exact.
  assign mag_ext    = (LAT_WIDTH + 1)'(lattice_mag_i);
  assign mag_abs    = mag_ext[LAT_WIDTH] ? $unsigned(-mag_ext) : $unsigned(mag_ext);
  assign idx_inc    = {1'b0, sweep_idx_q} + (CNT_WIDTH + 1)'(1);
  assign sweep_last = (idx_inc == {1'b0, sweeps_q});
  assign last_temp  = (t_step_q == '0) || (temp_q <= t_end_q) || ((temp_q - t_end_q) < t_step_q);
`ifdef ANNEAL_SQSUM_EN
  assign e_ext = PRD_WIDTH'(lattice_energy_i);
  assign e_sq  = $unsigned(e_ext * e_ext);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    t_end_d        = t_end_q;
    t_step_d       = t_step_q;
    temp_d         = temp_q;
    sweeps_d       = sweeps_q;
    burn_d         = burn_q;
    gap_d          = gap_q;
    gap_cnt_d      = gap_cnt_q;
    sweep_idx_d    = sweep_idx_q;
    samples_d      = samples_q;
    esum_d         = esum_q;
    msum_d         = msum_q;
    stat_valid_d   = stat_valid_q;
    stat_temp_d    = stat_temp_q;
    stat_esum_d    = stat_esum_q;
    stat_msum_d    = stat_msum_q;
    stat_samples_d = stat_samples_q;
`ifdef ANNEAL_SQSUM_EN
    sqsum_d        = sqsum_q;
    stat_sq_d      = stat_sq_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_PULSE;
          t_end_d     = cfg_t_end_i;
          t_step_d    = cfg_t_step_i;
          temp_d      = cfg_t_start_i;
          sweeps_d    = (cfg_sweeps_i == '0) ? CNT_WIDTH'(1) : cfg_sweeps_i;
          burn_d      = cfg_burn_in_i;
          gap_d       = (cfg_gap_i == '0) ? CNT_WIDTH'(1) : cfg_gap_i;
          sweep_idx_d = '0;
          samples_d   = '0;
          esum_d      = '0;
          msum_d      = '0;
`ifdef ANNEAL_SQSUM_EN
          sqsum_d     = '0;
`endif
        end
      end
      S_PULSE: begin
        gap_cnt_d = gap_q;
        state_d   = S_SETTLE;
      end
      S_SETTLE: begin
        if (gap_cnt_q <= CNT_WIDTH'(1)) begin
          state_d = S_SAMPLE;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_WIDTH'(1);
        end
      end
      S_SAMPLE: begin
        if (sweep_idx_q >= burn_q) begin
          esum_d    = esum_q + ACC_WIDTH'(lattice_energy_i);
          msum_d    = msum_q + ACC_WIDTH'(mag_abs);
          samples_d = samples_q + CNT_WIDTH'(1);
`ifdef ANNEAL_SQSUM_EN
          sqsum_d   = sqsum_q + SQ_WIDTH'(e_sq);
`endif
        end
        sweep_idx_d = sweep_idx_q + CNT_WIDTH'(1);
        if (sweep_last) begin
          state_d        = S_REPORT;
          stat_valid_d   = 1'b1;
          stat_temp_d    = temp_q;
          stat_esum_d    = esum_d;
          stat_msum_d    = msum_d;
          stat_samples_d = samples_d;
`ifdef ANNEAL_SQSUM_EN
          stat_sq_d      = sqsum_d;
`endif
        end else begin
          state_d = S_PULSE;
        end
      end
      S_REPORT: begin
        if (stat_valid_q && stat_if.stat_ready) begin
          stat_valid_d = 1'b0;
          sweep_idx_d  = '0;
          samples_d    = '0;
          esum_d       = '0;
          msum_d       = '0;
`ifdef ANNEAL_SQSUM_EN
          sqsum_d      = '0;
`endif
          if (last_temp) begin
            state_d = S_FIN;
          end else begin
            temp_d  = temp_q - t_step_q;
            state_d = S_PULSE;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort drops everything, including a pending record.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      stat_valid_d = 1'b0;
    end
    upd_d  = (state_d == S_PULSE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      t_end_q        <= '0;
      t_step_q       <= '0;
      temp_q         <= '0;
      sweeps_q       <= '0;
      burn_q         <= '0;
      gap_q          <= '0;
      gap_cnt_q      <= '0;
      sweep_idx_q    <= '0;
      samples_q      <= '0;
      esum_q         <= '0;
      msum_q         <= '0;
      stat_valid_q   <= 1'b0;
      stat_temp_q    <= '0;
      stat_esum_q    <= '0;
      stat_msum_q    <= '0;
      stat_samples_q <= '0;
      upd_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef ANNEAL_SQSUM_EN
      sqsum_q        <= '0;
      stat_sq_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      t_end_q        <= t_end_d;
      t_step_q       <= t_step_d;
      temp_q         <= temp_d;
      sweeps_q       <= sweeps_d;
      burn_q         <= burn_d;
      gap_q          <= gap_d;
      gap_cnt_q      <= gap_cnt_d;
      sweep_idx_q    <= sweep_idx_d;
      samples_q      <= samples_d;
      esum_q         <= esum_d;
      msum_q         <= msum_d;
      stat_valid_q   <= stat_valid_d;
      stat_temp_q    <= stat_temp_d;
      stat_esum_q    <= stat_esum_d;
      stat_msum_q    <= stat_msum_d;
      stat_samples_q <= stat_samples_d;
      upd_q          <= upd_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
`ifdef ANNEAL_SQSUM_EN
      sqsum_q        <= sqsum_d;
      stat_sq_q      <= stat_sq_d;
`endif
    end
  end

  assign update_enable_o         = upd_q;
  assign temperature_o           = temp_q;
  assign busy_o                  = busy_q;
  assign done_o                  = done_q;
  assign stat_if.stat_valid      = stat_valid_q;
  assign stat_if.stat_temp       = stat_temp_q;
  assign stat_if.stat_energy_sum = $signed(stat_esum_q);
  assign stat_if.stat_mag_sum    = stat_msum_q;
  assign stat_if.stat_samples    = stat_samples_q;
`ifdef ANNEAL_SQSUM_EN
  assign stat_if.stat_energy_sq_sum = stat_sq_q;
`else
  assign stat_if.stat_energy_sq_sum = '0;
`endif
endmodule
